// File: rtl/vtg_pkg.sv
// Shared definitions for the video timing / test pattern generator:
// pattern modes, default raster timing and the noise LFSR polynomial.
package vtg_pkg;

    localparam int unsigned CNT_W  = 12;
    localparam int unsigned LFSR_W = 16;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask over q[15:0]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned DEF_H_ACTIVE = 529;
    localparam int unsigned DEF_H_SS     = 544;
    localparam int unsigned DEF_H_SE     = 590;
    localparam int unsigned DEF_H_TOTAL  = 638;
    localparam int unsigned DEF_NT_ACT   = 240;
    localparam int unsigned DEF_NT_VS    = 245;
    localparam int unsigned DEF_NT_VE    = 248;
    localparam int unsigned DEF_NT_TOT   = 262;
    localparam int unsigned DEF_PL_ACT   = 288;
    localparam int unsigned DEF_PL_VS    = 304;
    localparam int unsigned DEF_PL_VE    = 308;
    localparam int unsigned DEF_PL_TOT   = 312;

    typedef enum logic [2:0] {
        MODE_SOLID  = 3'd0,
        MODE_GRAD   = 3'd1,
        MODE_BARS   = 3'd2,
        MODE_NOISE  = 3'd3,
        MODE_SCROLL = 3'd4
    } vtg_mode_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/vtg_lfsr.sv
// 16-bit noise LFSR. o_sample is the value for the current tick, so a
// load and a step on the same tick present step(seed) immediately.
module vtg_lfsr
    import vtg_pkg::*;
#(
    parameter int unsigned OUT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [LFSR_W-1:0] i_seed,
    output logic [OUT_W-1:0]  o_sample
);

    logic [LFSR_W-1:0] r_q;
    logic [LFSR_W-1:0] w_base;
    logic [LFSR_W-1:0] w_next;

    // all-zero is a lock-up state; recover by reloading the seed
    always_comb begin
        w_base = i_load ? i_seed : r_q;
        w_next = i_step ? lfsr_step(w_base) : w_base;
        if (w_next == '0) begin
            w_next = i_seed;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= i_seed;
        end else if (i_en) begin
            r_q <= w_next;
        end
    end

    assign o_sample = OUT_W'(w_next);

endmodule

// File: rtl/vtg_pattern.sv
// Video timing generator with selectable test patterns. Timing select and
// pattern mode are latched at frame start so a frame is never mixed.
module vtg_pattern
    import vtg_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_SS       = DEF_H_SS,
    parameter int unsigned H_SE       = DEF_H_SE,
    parameter int unsigned H_TOTAL    = DEF_H_TOTAL,
    parameter int unsigned NT_ACT     = DEF_NT_ACT,
    parameter int unsigned NT_VS      = DEF_NT_VS,
    parameter int unsigned NT_VE      = DEF_NT_VE,
    parameter int unsigned NT_TOT     = DEF_NT_TOT,
    parameter int unsigned PL_ACT     = DEF_PL_ACT,
    parameter int unsigned PL_VS      = DEF_PL_VS,
    parameter int unsigned PL_VE      = DEF_PL_VE,
    parameter int unsigned PL_TOT     = DEF_PL_TOT,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned NOISE_LOCK = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pal,
    input  logic              scandouble,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] level,
    output logic              ce_pix,
    output logic              HBlank,
    output logic              HSync,
    output logic              VBlank,
    output logic              VSync,
    output logic [DATA_W-1:0] video,
    output logic [7:0]        frame
);

    logic              r_ce;
    logic [CNT_W-1:0]  r_hc;
    logic [CNT_W-1:0]  r_vc;
    logic [7:0]        r_frame;
    logic              r_pal;
    logic              r_sd;
    vtg_mode_e         r_mode;
    logic              r_hblank;
    logic              r_hsync;
    logic              r_vblank;
    logic              r_vsync;
    logic [DATA_W-1:0] r_video;
    logic [7:0]        r_frame_o;

    logic              w_fstart;
    logic              w_pal;
    logic              w_sd;
    vtg_mode_e         w_mode;
    logic [CNT_W-1:0]  w_v_act;
    logic [CNT_W-1:0]  w_v_vs;
    logic [CNT_W-1:0]  w_v_ve;
    logic [CNT_W-1:0]  w_v_tot;
    logic              w_hblank;
    logic              w_hsync;
    logic              w_vblank;
    logic              w_vsync;
    logic [8:0]        w_ly;
    logic [8:0]        w_t;
    logic [7:0]        w_scroll8;
    logic [CNT_W-1:0]  w_div;
    logic [2:0]        w_bar;
    logic [7:0]        w_bar8;
    logic [DATA_W-1:0] w_noise;
    logic [DATA_W-1:0] w_video;

    // map an 8-bit level onto DATA_W bits (MSB-aligned)
    function automatic logic [DATA_W-1:0] scale8(input logic [7:0] v);
        return DATA_W'({v, {DATA_W{1'b0}}} >> 8);
    endfunction

    always_comb begin
        w_fstart = (r_hc == '0) && (r_vc == '0);
        w_pal    = w_fstart ? pal : r_pal;
        w_sd     = w_fstart ? scandouble : r_sd;
        w_mode   = w_fstart ? vtg_mode_e'(mode) : r_mode;

        w_v_act  = CNT_W'(w_pal ? PL_ACT : NT_ACT) << w_sd;
        w_v_vs   = CNT_W'(w_pal ? PL_VS  : NT_VS)  << w_sd;
        w_v_ve   = CNT_W'(w_pal ? PL_VE  : NT_VE)  << w_sd;
        w_v_tot  = CNT_W'(w_pal ? PL_TOT : NT_TOT) << w_sd;

        w_hblank = r_hc >= CNT_W'(H_ACTIVE);
        w_hsync  = (r_hc >= CNT_W'(H_SS)) && (r_hc < CNT_W'(H_SE));
        w_vblank = r_vc >= w_v_act;
        w_vsync  = (r_vc >= w_v_vs) && (r_vc < w_v_ve);

        w_ly      = 9'(w_sd ? (r_vc >> 1) : r_vc);
        w_t       = w_ly + 9'({r_frame, 2'b00});
        w_scroll8 = w_t[8] ? ~w_t[7:0] : w_t[7:0];

        w_div  = r_hc / CNT_W'(66);
        w_bar  = (w_div > CNT_W'(7)) ? 3'd7 : 3'(w_div);
        w_bar8 = 8'(w_bar) * 8'd36;

        case (w_mode)
            MODE_GRAD:   w_video = DATA_W'(r_hc[8:1]);
            MODE_BARS:   w_video = scale8(w_bar8);
            MODE_NOISE:  w_video = w_noise;
            MODE_SCROLL: w_video = scale8(w_scroll8);
            default:     w_video = level;
        endcase
        if (w_hblank || w_vblank) begin
            w_video = '0;
        end
    end

    vtg_lfsr #(
        .OUT_W (DATA_W)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .i_en     (r_ce),
        .i_load   (w_fstart && (NOISE_LOCK != 0)),
        .i_step   (!w_hblank && !w_vblank),
        .i_seed   (LFSR_SEED),
        .o_sample (w_noise)
    );

    // raster counters and registered outputs, advanced on ce ticks only
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ce      <= 1'b0;
            r_hc      <= '0;
            r_vc      <= '0;
            r_frame   <= '0;
            r_pal     <= 1'b0;
            r_sd      <= 1'b0;
            r_mode    <= MODE_SOLID;
            r_hblank  <= 1'b0;
            r_hsync   <= 1'b0;
            r_vblank  <= 1'b0;
            r_vsync   <= 1'b0;
            r_video   <= '0;
            r_frame_o <= '0;
        end else begin
            r_ce <= scandouble ? 1'b1 : ~r_ce;
            if (r_ce) begin
                if (w_fstart) begin
                    r_pal  <= pal;
                    r_sd   <= scandouble;
                    r_mode <= vtg_mode_e'(mode);
                end
                if (r_hc == CNT_W'(H_TOTAL - 1)) begin
                    r_hc <= '0;
                    if (r_vc == w_v_tot - CNT_W'(1)) begin
                        r_vc    <= '0;
                        r_frame <= r_frame + 8'd1;
                    end else begin
                        r_vc <= r_vc + CNT_W'(1);
                    end
                end else begin
                    r_hc <= r_hc + CNT_W'(1);
                end
                r_hblank  <= w_hblank;
                r_hsync   <= w_hsync;
                r_vblank  <= w_vblank;
                r_vsync   <= w_vsync;
                r_video   <= w_video;
                r_frame_o <= r_frame;
            end
        end
    end

    assign ce_pix = r_ce;
    assign HBlank = r_hblank;
    assign HSync  = r_hsync;
    assign VBlank = r_vblank;
    assign VSync  = r_vsync;
    assign video  = r_video;
    assign frame  = r_frame_o;

endmodule

// File: doc/vtg_pattern.md
VTG_PATTERN -- requirements
Module: vtg_pattern

Interface
REQ-001 Parameter DATA_W, default 8: video sample width, 4..12.
REQ-002 Parameter H_ACTIVE/H_SS/H_SE/H_TOTAL, defaults 529/544/590/638: active pixels, HSync start, HSync end (exclusive), line length, in ce ticks.
REQ-003 Parameter NT_ACT/NT_VS/NT_VE/NT_TOT, defaults 240/245/248/262: NTSC single-rate active lines, VSync start, VSync end (exclusive), total lines.
REQ-004 Parameter PL_ACT/PL_VS/PL_VE/PL_TOT, defaults 288/304/308/312: PAL single-rate equivalents.
REQ-005 Parameter LFSR_SEED, default 16'hACE1: noise seed, nonzero.
REQ-006 Parameter NOISE_LOCK, default 1: 1 = reseed the LFSR every frame, giving a static noise image.
REQ-007 Ports: clk in 1, pixel clock domain; reset in 1, synchronous active-high.
REQ-008 Ports: pal in 1, PAL timing select; scandouble in 1, doubled line rate.
REQ-009 Ports: mode in 3, pattern select; level in DATA_W, solid-fill value.
REQ-010 Ports: ce_pix out 1; HBlank, HSync, VBlank, VSync out 1 each; video out DATA_W; frame out 8, frame counter.

Function
REQ-011 ce_pix: held 1 while scandouble=1; otherwise toggles every clk.
REQ-012 Counters hc, vc and all output registers advance only on clk edges where ce_pix=1.
REQ-013 hc counts 0..H_TOTAL-1 and wraps; vc increments at each hc wrap and wraps at V_TOT-1.
REQ-014 Vertical constants: the selected NT_* or PL_* set, each left-shifted by 1 when scandouble=1.
REQ-015 pal, scandouble and mode are sampled only at frame start (hc=0, vc=0); mid-frame changes take effect at the next frame.
REQ-016 frame increments by 1, mod 256, at each vc wrap.
REQ-017 Outputs are registered, one ce tick after the counter value they describe; video, syncs and blanks share this latency.
REQ-018 HBlank = hc>=H_ACTIVE; HSync = H_SS<=hc<H_SE; VBlank = vc>=V_ACT; VSync = V_VS<=vc<V_VE.
REQ-019 video = 0 whenever HBlank or VBlank is true.
REQ-020 Line index ly = vc>>scandouble.
REQ-021 Mode 0, solid: video = level.
REQ-022 Mode 1, gradient: video = hc[8:1], zero-extended or truncated to DATA_W.
REQ-023 Mode 2, bars: bar b = min(hc/66, 7); video = b*36 scaled to DATA_W (8-bit values 0,36,...,252).
REQ-024 Mode 3, noise: 16-bit Fibonacci LFSR, taps 16,14,13,11, steps once per active ce tick; video = its low DATA_W bits (zero-extended if DATA_W>16).
REQ-025 Mode 3 reseed: with NOISE_LOCK=1 the LFSR loads LFSR_SEED at frame start; with NOISE_LOCK=0 it free-runs.
REQ-026 Mode 4, scroll: t = ly + 4*frame, 9 bits; 8-bit v = t[8] ? ~t[7:0] : t[7:0]; video = v scaled to DATA_W.
REQ-027 Modes 5-7: behave as mode 0.
REQ-028 The LFSR never reaches the all-zero state; if it does, it loads LFSR_SEED.

Reset
REQ-029 On reset: hc=vc=0, frame=0, LFSR=LFSR_SEED, ce_pix=0, all sync/blank outputs 0, video 0, sampled mode=0.
REQ-030 Reset mid-frame aborts the frame; the first ce tick after release starts a new frame at hc=0, vc=0 and samples pal, scandouble and mode.

Structure
REQ-031 Package vtg_pkg holds the mode enumeration, default timing constants and the LFSR tap mask.
REQ-032 Sub-module vtg_lfsr, a 16-bit LFSR with step, load and seed inputs; everything else stays inline.

Verification
REQ-033 NTSC, scandouble=0: HSync period 638 ce ticks, high 46 ticks; VSync high for lines 245-247; frame = 262 lines.
REQ-034 PAL, scandouble=1: frame = 624 lines; VBlank first set at vc=576; ce_pix constantly 1.
REQ-035 Mode 2, DATA_W=8: hc=65 -> 0, hc=66 -> 36, hc=528 -> 252, hc=529 -> 0 (blank).
REQ-036 Mode 3, NOISE_LOCK=1: two consecutive frames produce identical video streams; first active sample = low byte of the first LFSR step from 16'hACE1.
REQ-037 Mode switched 0->2 at vc=100: rest of the frame stays solid level; bars appear from the next frame.
REQ-038 Reset pulsed at vc=50, hc=300: outputs 0 during reset; afterwards frame=0 and sync timing restarts from hc=0.
